croc_irq_ctrl: RTL

CROC_IRQ_CTRL -- requirements
Module: croc_irq_ctrl

---
 rtl/croc_pkg.sv | 28 ++
 rtl/croc_irq_sync.sv | 27 ++
 rtl/croc_irq_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/croc_pkg.sv
// Shared constants for the croc interrupt controller: line count, register
// offsets and the byte-enable expansion helper.
package croc_pkg;

    localparam int unsigned NumIrqs = 16;

    localparam logic [31:0] IrqPendingOffset = 32'h0;
    localparam logic [31:0] IrqEnableOffset  = 32'h4;
    localparam logic [31:0] IrqModeOffset    = 32'h8;
    localparam logic [31:0] IrqStatusOffset  = 32'hC;

    typedef enum logic [1:0] {
        RegPending = IrqPendingOffset[3:2],
        RegEnable  = IrqEnableOffset[3:2],
        RegMode    = IrqModeOffset[3:2],
        RegStatus  = IrqStatusOffset[3:2]
    } irq_reg_e;

    // Expands the four byte enables into a 32-bit per-bit write mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/croc_irq_sync.sv
// Two-flop synchronizer bank, one chain per interrupt line. Only built when
// CROC_IRQ_CTRL_SYNC_EN is defined.
module croc_irq_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/croc_irq_ctrl.sv
// Fast-interrupt controller: PENDING/ENABLE/MODE/STATUS behind a single-cycle
// OBI port. Define CROC_IRQ_CTRL_SYNC_EN to add 2-flop input synchronizers.
module croc_irq_ctrl #(
    parameter int unsigned NumIrqs = croc_pkg::NumIrqs
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumIrqs-1:0] irq_src_i,
    input  logic               obi_req_i,
    output logic               obi_gnt_o,
    input  logic [31:0]        obi_addr_i,
    input  logic               obi_we_i,
    input  logic [3:0]         obi_be_i,
    input  logic [31:0]        obi_wdata_i,
    output logic               obi_rvalid_o,
    output logic [31:0]        obi_rdata_o,
    output logic               obi_err_o,
    output logic [NumIrqs-1:0] irqs_o
);

    import croc_pkg::*;

    logic [NumIrqs-1:0] pending_q, enable_q, mode_q, prev_q;
    logic [NumIrqs-1:0] pending_d, enable_d, mode_d, pending_clr;
    logic [NumIrqs-1:0] sample, irq_set;
    logic [NumIrqs-1:0] lane_mask, wdata;
    logic [31:0]        wmask;
    logic [31:0]        rdata_d, rdata_q;
    logic               err_d, err_q, rvalid_q;
    irq_reg_e           reg_sel;
    logic               unused_bits;

`ifdef CROC_IRQ_CTRL_SYNC_EN
    croc_irq_sync #(
        .Width (NumIrqs)
    ) i_irq_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (irq_src_i),
        .q_o    (sample)
    );
`else
    assign sample = irq_src_i;
`endif

    assign wmask     = be_to_mask(obi_be_i);
    assign lane_mask = wmask[NumIrqs-1:0];
    assign wdata     = obi_wdata_i[NumIrqs-1:0];
    assign reg_sel   = irq_reg_e'(obi_addr_i[3:2]);

    // Only the register index and the implemented low bits matter.
    assign unused_bits = ^{obi_addr_i[31:4], obi_addr_i[1:0],
                           obi_wdata_i[31:NumIrqs], wmask[31:NumIrqs]};

    // Level lines set every cycle they are high; edge lines only on 0->1.
    assign irq_set = sample & (~mode_q | ~prev_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        enable_d    = enable_q;
        mode_d      = mode_q;
        pending_clr = '0;
        rdata_d     = '0;
        err_d       = 1'b0;
        if (obi_req_i) begin
            if (obi_we_i) begin
                unique case (reg_sel)
                    RegPending: pending_clr = wdata & lane_mask;
                    RegEnable:  enable_d    = (enable_q & ~lane_mask) | (wdata & lane_mask);
                    RegMode:    mode_d      = (mode_q & ~lane_mask) | (wdata & lane_mask);
                    RegStatus:  err_d       = 1'b1;
                    default:    ;
                endcase
            end else begin
                unique case (reg_sel)
                    RegPending: rdata_d = 32'(pending_q);
                    RegEnable:  rdata_d = 32'(enable_q);
                    RegMode:    rdata_d = 32'(mode_q);
                    RegStatus:  rdata_d = 32'(pending_q & enable_q);
                    default:    ;
                endcase
            end
        end
        // A new set beats a W1C clear landing in the same cycle.
        pending_d = (pending_q & ~pending_clr) | irq_set;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_ni) begin
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            prev_q    <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            prev_q    <= sample;
            rvalid_q  <= obi_req_i;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign obi_gnt_o    = obi_req_i;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign irqs_o       = pending_q & enable_q;

endmodule
